pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 120 ++++++++++++
 tb/tb_pipe_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/redirect control with optional MDU busy tracking.
// Optional feature macro: PIPE_CTRL_MDU_EN (MDU FSM and stall_cycles counter).
module pipe_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        D_hazard,
    input  logic        D_mdu_use,
    input  logic        E_mdu_start,
    input  logic        E_mdu_div,
    input  logic        M_req,
    output logic        PC_en,
    output logic        FD_en,
    output logic        DE_en,
    output logic        EM_en,
    output logic        MW_en,
    output logic        DE_flush,
    output logic        Req,
    output logic        mdu_busy,
    output logic [15:0] stall_cycles
);

    logic stall;

    assign Req = M_req & ~reset;

`ifdef PIPE_CTRL_MDU_EN

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       start_ok;
    logic [3:0] load_val;

    // A squashed E instruction never starts the MDU.
    assign start_ok = E_mdu_start & ~Req;
    assign load_val = E_mdu_div ? 4'd10 : 4'd5;

    assign mdu_busy = (state_q == BUSY) & ~reset;
    assign stall = D_hazard
                 | (~reset & D_mdu_use & (mdu_busy | E_mdu_start));

    // MDU countdown state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: load on start, count down while busy, reload on restart.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = BUSY;
                    cnt_d   = load_val;
                end
            end
            BUSY: begin
                if (start_ok) begin
                    cnt_d = load_val;
                end else if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Saturating count of cycles where the front end is actually held.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= 16'd0;
        end else if (stall & ~Req & (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

`else

    logic unused_mdu;

    assign unused_mdu   = ^{clk, D_mdu_use, E_mdu_start, E_mdu_div};
    assign mdu_busy     = 1'b0;
    assign stall_cycles = 16'd0;
    assign stall        = D_hazard;

`endif

    // Enables: a redirect wins over a stall; a stall freezes PC/F-D and bubbles D/E.
    always_comb begin
        PC_en    = 1'b1;
        FD_en    = 1'b1;
        DE_en    = 1'b1;
        EM_en    = 1'b1;
        MW_en    = 1'b1;
        DE_flush = 1'b0;
        if (stall & ~Req) begin
            PC_en    = 1'b0;
            FD_en    = 1'b0;
            DE_flush = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle scoreboard plus directed checks.
// Follows the build's PIPE_CTRL_MDU_EN setting.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_MDU_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, D_hazard, D_mdu_use;
    logic        E_mdu_start, E_mdu_div, M_req;
    logic        PC_en, FD_en, DE_en, EM_en, MW_en;
    logic        DE_flush, Req, mdu_busy;
    logic [15:0] stall_cycles;

    pipe_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .D_hazard     (D_hazard),
        .D_mdu_use    (D_mdu_use),
        .E_mdu_start  (E_mdu_start),
        .E_mdu_div    (E_mdu_div),
        .M_req        (M_req),
        .PC_en        (PC_en),
        .FD_en        (FD_en),
        .DE_en        (DE_en),
        .EM_en        (EM_en),
        .MW_en        (MW_en),
        .DE_flush     (DE_flush),
        .Req          (Req),
        .mdu_busy     (mdu_busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ctl;
        logic [15:0] sc;
        bit          sc_ok;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          m_left = 0;
    int unsigned m_sc   = 0;
    bit          m_init = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // One cycle: drive, push expectation, sample mid-cycle, advance model.
    task automatic step(input bit rst, input bit hz, input bit mu,
                        input bit st, input bit dv, input bit mr);
        exp_t e, o;
        bit   req, busy, stl;
        @(negedge clk);
        reset = rst; D_hazard = hz; D_mdu_use = mu;
        E_mdu_start = st; E_mdu_div = dv; M_req = mr;
        req  = mr & ~rst;
        busy = MDU & (m_left > 0) & ~rst;
        stl  = hz | (MDU & ~rst & mu & (busy | st));
        e.ctl = {~(stl & ~req), ~(stl & ~req), stl & ~req,
                 1'b1, 1'b1, 1'b1, req, busy};
        e.sc    = m_sc[15:0];
        e.sc_ok = m_init;
        sb.push_back(e);
        #2;
        o = sb.pop_front();
        chk("ctl", {24'd0, PC_en, FD_en, DE_flush, DE_en, EM_en,
                    MW_en, Req, mdu_busy}, {24'd0, o.ctl});
        if (o.sc_ok) chk("sc", {16'd0, stall_cycles}, {16'd0, o.sc});
        if (rst) begin
            m_left = 0;
            m_sc   = 0;
            m_init = 1'b1;
        end else begin
            if (MDU && stl && !req && m_sc != 32'hFFFF) m_sc++;
            if (MDU && st && !req) m_left = dv ? 10 : 5;
            else if (m_left > 0) m_left--;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic hold_hazard(input int n);
        @(negedge clk);
        reset = 0; D_hazard = 1; D_mdu_use = 0;
        E_mdu_start = 0; E_mdu_div = 0; M_req = 0;
        repeat (n) @(posedge clk);
        if (MDU) m_sc = (m_sc + n > 32'hFFFF) ? 32'hFFFF : m_sc + n;
        m_left = 0;
    endtask

    int busy_n;

    initial begin
        reset = 1; D_hazard = 0; D_mdu_use = 0;
        E_mdu_start = 0; E_mdu_div = 0; M_req = 0;

        step(1, 1, 1, 1, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_sc", {16'd0, stall_cycles}, 32'd0);
        chk("rst_busy", {31'd0, mdu_busy}, 32'd0);

        idle(1);
        step(0, 1, 0, 0, 0, 0);
        idle(1);

        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        busy_n = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 0, 0, 0);
            busy_n += mdu_busy;
        end
        chk("mul_busy_n", busy_n, MDU ? 5 : 0);
        chk("mul_sc", {16'd0, stall_cycles}, MDU ? 6 : 0);

        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        busy_n = 0;
        for (int i = 0; i < 11; i++) begin
            step(0, 0, 0, 0, 0, 0);
            busy_n += mdu_busy;
        end
        chk("div_busy_n", busy_n, MDU ? 10 : 0);
        chk("div_sc", {16'd0, stall_cycles}, 32'd0);

        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("req_idle", {31'd0, mdu_busy}, 32'd0);

        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        idle(3);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("rst_mid_busy", {31'd0, mdu_busy}, 32'd0);
        chk("rst_mid_sc", {16'd0, stall_cycles}, 32'd0);

        step(0, 0, 0, 1, 0, 0);
        idle(2);
        step(0, 0, 1, 1, 1, 0);
        idle(11);

        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 1, 1, 1);
        idle(5);

        step(1, 0, 0, 0, 0, 0);
        hold_hazard(70000);
        step(0, 0, 0, 0, 0, 0);
        chk("sat", {16'd0, stall_cycles}, MDU ? 32'hFFFF : 32'd0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("no_wrap", {16'd0, stall_cycles}, MDU ? 32'hFFFF : 32'd0);

        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 40) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
